// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 128x32 data memory; CPU on port 0, DMA/debug on port 1.
// Latency: grant one cycle after a request seen in IDLE; read data/valid one cycle after each read beat.
// Backpressure: a port holds req/addr/we/wdata until its gnt; ownership is capped at MAX_BURST beats.
// Optional feature: define DMEM_ARB_RR_EN for round-robin IDLE tie-break (default: port 0 wins ties).
module dmem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic              i_p0_last,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic              i_p1_last,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic              o_p0_gnt,
    output logic              o_p1_gnt,
    output logic              o_p0_rvalid,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_p0_rdata,
    output logic [DATA_W-1:0] o_p1_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    // Counter is compared one bit wider so the increment never wraps before the compare.
    localparam logic [4:0] LP_MAX = 5'(MAX_BURST);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_last_served;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_beat;
    logic              w_own_req;
    logic              w_own_last;
    logic              w_other_req;
    logic [4:0]        w_cnt_inc;
    logic              w_cap;
    logic              w_release;
    logic              w_tie_p1;

    // Grants, owner-side selects and release decision for the current cycle.
    always_comb begin
        w_gnt0      = (r_state == S_OWN0) && i_p0_req;
        w_gnt1      = (r_state == S_OWN1) && i_p1_req;
        w_beat      = w_gnt0 || w_gnt1;
        w_own_req   = 1'b0;
        w_own_last  = 1'b0;
        w_other_req = 1'b0;
        if (r_state == S_OWN0) begin
            w_own_req   = i_p0_req;
            w_own_last  = i_p0_last;
            w_other_req = i_p1_req;
        end else if (r_state == S_OWN1) begin
            w_own_req   = i_p1_req;
            w_own_last  = i_p1_last;
            w_other_req = i_p0_req;
        end
        w_cnt_inc = {1'b0, r_cnt} + 5'd1;
        w_cap     = (w_cnt_inc >= LP_MAX);
        // With req high a beat is taken, so last/cap only ever apply to a real beat.
        w_release = (r_state != S_IDLE) && (!w_own_req || w_own_last || w_cap);
`ifdef DMEM_ARB_RR_EN
        // Round-robin: a tie goes to whichever port was not served most recently.
        w_tie_p1 = ~r_last_served;
`else
        // Fixed priority: port 0 always wins a tie; last_served is tracked but not consulted.
        w_tie_p1 = r_last_served & 1'b0;
`endif
    end

    // Memory drive: only the granted beat reaches the memory, otherwise everything is held at zero.
    always_comb begin
        o_p0_gnt    = w_gnt0;
        o_p1_gnt    = w_gnt1;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        if (w_gnt0) begin
            o_mem_addr  = i_p0_addr;
            o_mem_wdata = i_p0_wdata;
            o_mem_read  = ~i_p0_we;
            o_mem_write = i_p0_we;
        end else if (w_gnt1) begin
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
            o_mem_read  = ~i_p1_we;
            o_mem_write = i_p1_we;
        end
    end

    // Ownership FSM: arbitrate in IDLE, count beats while owning, hand over or idle on release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_last_served <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 4'd0;
                    if (i_p0_req && i_p1_req) begin
                        r_state <= w_tie_p1 ? S_OWN1 : S_OWN0;
                    end else if (i_p0_req) begin
                        r_state <= S_OWN0;
                    end else if (i_p1_req) begin
                        r_state <= S_OWN1;
                    end
                end
                S_OWN0, S_OWN1: begin
                    if (w_release) begin
                        // A releasing port that still wants service must go back through IDLE.
                        if (w_other_req) begin
                            r_state <= (r_state == S_OWN0) ? S_OWN1 : S_OWN0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                        r_cnt         <= 4'd0;
                        r_last_served <= (r_state == S_OWN1);
                    end else if (w_beat) begin
                        r_cnt <= w_cnt_inc[3:0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Read return: capture memory data on each read beat; valid lasts exactly one cycle per beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_gnt0 && !i_p0_we;
            r_p1_rvalid <= w_gnt1 && !i_p1_we;
            if (w_gnt0 && !i_p0_we) begin
                r_p0_rdata <= i_mem_rdata;
            end
            if (w_gnt1 && !i_p1_we) begin
                r_p1_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_p0_rvalid = r_p0_rvalid;
    assign o_p1_rvalid = r_p1_rvalid;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_rdata  = r_p1_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 128x32 word-addressed data memory. It lets the CPU datapath (port 0) and a secondary master such as a DMA or debug loader (port 1) share the single memory port. It grants ownership through a request/grant handshake and bounds each ownership to a burst limit. It drives the memory's address, write-data, MemRead and MemWrite controls, and returns registered read data with a valid strobe.

## Interface
- ADDR_W, 7, word address width (128 words)
- DATA_W, 32, data width
- MAX_BURST, 4, maximum beats per ownership (1..15)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- p0_req / p1_req  input  1  port requests a beat; held with addr/we/wdata stable
- p0_we / p1_we  input  1  1 = write beat, 0 = read beat
- p0_last / p1_last  input  1  current beat is the port's final beat
- p0_addr / p1_addr  input  ADDR_W  word address
- p0_wdata / p1_wdata  input  DATA_W  write data
- p0_gnt / p1_gnt  output  1  beat accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  output  1  registered read data valid
- p0_rdata / p1_rdata  output  DATA_W  registered read data
- mem_addr  output  ADDR_W  to memory addr
- mem_wdata  output  DATA_W  to memory write_data
- mem_read  output  1  to memory MemRead
- mem_write  output  1  to memory MemWrite
- mem_rdata  input  DATA_W  from memory read_data (combinational)

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, beat counter (4 bits), last_served, per-port rdata/rvalid.
- IDLE: no grant and no memory access. On any request, the next state is OWNx for the winning port. Only one requester: that port wins. Both requesting: winner per Configuration.
- OWNx: px_gnt = px_req. Every other port's gnt is 0. A cycle with px_gnt=1 is one beat:
  - the memory is driven with px_addr and px_wdata;
  - mem_read = ~px_we and mem_write = px_we;
  - the beat counter increments.
- Ownership release occurs at the end of the cycle in which any of these holds:
  - a beat with px_last=1;
  - a beat with the counter reaching MAX_BURST;
  - px_req=0 (no beat taken).
- On release: if the other port's req is high, the next state is OWN(other). Otherwise the next state is IDLE. The counter clears. last_served is set to x.
- A releasing port that still requests must re-arbitrate through IDLE, which costs one bubble cycle.
- With no beat in progress, the memory outputs are held to mem_read=0, mem_write=0, mem_addr=0 and mem_wdata=0.
- Read beat: at the clock edge, px_rdata <= mem_rdata and px_rvalid <= 1. px_rvalid is 0 in every cycle not following a read beat of that port. px_rdata holds its last value otherwise.
- Write beats: the memory commits the write on the same rising edge. No rvalid is produced.
- Arithmetic: the beat counter compares to MAX_BURST with an unsigned compare. The counter never exceeds MAX_BURST.

## Timing
- Reset values: state=IDLE, counter=0, last_served=1 (port 0 wins the first tie). All gnt, rvalid, mem_read and mem_write are 0. All rdata and mem_addr/mem_wdata are 0.
- Reset assertion mid-burst immediately forces IDLE and clears rvalid. No memory control is driven while reset is low.
- Grant latency: req rising in IDLE at cycle n gives gnt at cycle n+1.
- Owner handover with the other port waiting: the next owner's gnt arrives in the cycle right after release, with zero bubbles.
- Read latency: a beat in cycle n gives rvalid/rdata in cycle n+1. Back-to-back reads give rvalid high continuously.
- Simultaneous requests in IDLE: exactly one gnt is granted. The other waits at least until the release.

## Configuration
- DMEM_ARB_RR_EN defined: an IDLE tie goes to the port that is not last_served (round-robin).
- DMEM_ARB_RR_EN undefined: an IDLE tie always goes to port 0 (fixed priority). last_served is still maintained but unused for tie-break.
- Handover on release is identical in both builds.

## Test plan
- Single read: memory word 2 = 3; p0 reads addr 2 with last=1 → p0_gnt in cycle 1, p0_rvalid=1 and p0_rdata=3 in cycle 2, then IDLE.
- Write then read: p1 writes 0xDEAD to addr 10, then reads addr 10 → memory word 10 = 0xDEAD, p1_rdata=0xDEAD one cycle after the read beat.
- Burst cap with MAX_BURST=4: p0 holds req through 6 reads of addrs 0..5 with last=0 → exactly 4 beats granted, one IDLE bubble, then remaining beats granted.
- Tie, DMEM_ARB_RR_EN defined: both ports request from reset → p0 is served first, p1 next with no bubble. A later simultaneous tie from IDLE after p1 was last served goes to p0. With the macro undefined, p0 always wins ties.
- Handover: p0 reads 3 beats with last on beat 3 while p1 requests → p1_gnt in the next cycle, with mem_read never low between the owners.
- Reset mid-burst: reset driven low during p0 beat 2 → gnt, rvalid, mem_read and mem_write drop immediately. After release, p0 requires a fresh grant cycle.
